data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/data_mem_ctrl_if.sv | 33 +++
 rtl/data_mem_ctrl_load_align.sv | 34 +++
 rtl/data_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_mem_pkg
// Brief  : Shared access-size encodings and controller FSM state type.
// Rev    : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] c_sizeByte  = 2'b00;
    localparam logic [1:0] c_sizeHalf  = 2'b01;
    localparam logic [1:0] c_sizeWord  = 2'b10;
    localparam logic [1:0] c_sizeDword = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t c_stIdle = 2'd0;
    localparam state_t c_stWait = 2'd1;
    localparam state_t c_stResp = 2'd2;

    function automatic int sizeBytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl_if
// Brief  : Request/response bus between a load/store unit and data_mem_ctrl.
// Rev    : 1.0
// ============================================================================
interface data_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl_load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Selects the load lane from a memory word and sign/zero extends it.
// Rev    : 1.0
// ============================================================================
module load_align
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0]            word,
    input  wire logic [$clog2(DATA_W/8)-1:0]  offset,
    input  wire logic [1:0]                   size,
    input  wire logic                         isUnsigned,
    output logic      [DATA_W-1:0]            data
);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic              w_sign;
    int                w_nBits;

    always_comb begin
        w_shifted = word >> {offset, 3'b000};
        w_nBits   = (sizeBytes(size) * 8 > DATA_W) ? DATA_W : sizeBytes(size) * 8;
        w_mask    = ~({DATA_W{1'b1}} << w_nBits);
        // Sign bit is the highest bit still covered by the lane mask.
        w_sign    = ~isUnsigned & (|(w_shifted & (w_mask ^ (w_mask >> 1))));
        data      = (w_shifted & w_mask) | ({DATA_W{w_sign}} & ~w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl
// Brief  : Wait-stated data memory with byte/half/word/dword loads and stores.
//          Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
// Rev    : 1.0
// ============================================================================
module data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  wire logic      CLK,
    input  wire logic      reset,
    data_mem_ctrl_if.slave bus,
    output logic           busy
);

    localparam int c_bytes = DATA_W / 8;
    localparam int c_offW  = $clog2(c_bytes);
    localparam int c_idxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state;
    logic [3:0]        r_waitCnt;
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rspValid;
    logic              r_rspFault;
    logic [DATA_W-1:0] r_rspRdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_inIdle;
    logic              w_accept;
    logic              w_enterResp;
    logic              w_write;
    logic              w_unsigned;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_wordIdx;
    logic [c_idxW-1:0] w_idx;
    logic [c_offW-1:0] w_rawOff;
    logic [c_offW-1:0] w_alignMask;
    logic [c_offW-1:0] w_off;
    logic              w_alignFault;
    logic              w_fault;
    logic [c_bytes-1:0] w_byteEn;
    logic [DATA_W-1:0] w_wdataSh;
    logic [DATA_W-1:0] w_memWord;
    logic [DATA_W-1:0] w_loadData;

    assign w_inIdle = (r_state == c_stIdle);
    assign w_accept = w_inIdle & bus.req_valid;

    // With no wait states the access completes on the accepting edge, so it is
    // taken straight from the bus while idle.
    assign w_write    = w_inIdle ? bus.req_write    : r_write;
    assign w_unsigned = w_inIdle ? bus.req_unsigned : r_unsigned;
    assign w_size     = w_inIdle ? bus.req_size     : r_size;
    assign w_addr     = w_inIdle ? bus.req_addr     : r_addr;
    assign w_wdata    = w_inIdle ? bus.req_wdata    : r_wdata;

    assign w_enterResp = w_inIdle ? (w_accept && (WAIT_CYC == 0))
                                  : ((r_state == c_stWait) && (int'(r_waitCnt) == WAIT_CYC - 1));

    assign w_wordIdx   = w_addr >> c_offW;
    assign w_idx       = w_wordIdx[c_idxW-1:0];
    assign w_rawOff    = w_addr[c_offW-1:0];
    assign w_alignMask = c_offW'(sizeBytes(w_size) - 1);
    assign w_off       = w_rawOff & ~w_alignMask;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_alignFault = |(w_rawOff & w_alignMask);
`else
    assign w_alignFault = 1'b0;
`endif

    assign w_fault = ((DATA_W == 32) && (w_size == c_sizeDword))
                   || (w_wordIdx >= ADDR_W'(DEPTH))
                   || w_alignFault;

    assign w_byteEn  = c_bytes'((1 << sizeBytes(w_size)) - 1) << w_off;
    assign w_wdataSh = w_wdata << {w_off, 3'b000};
    assign w_memWord = r_mem[w_idx];

    load_align #(.DATA_W(DATA_W)) u_loadAlign (
        .word       (w_memWord),
        .offset     (w_off),
        .size       (w_size),
        .isUnsigned (w_unsigned),
        .data       (w_loadData)
    );

    // Contents survive reset; a reset edge blocks any pending commit.
    always_ff @(posedge CLK) begin
        if (reset && w_enterResp && w_write && !w_fault) begin
            for (int i = 0; i < c_bytes; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wdataSh[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= c_stIdle;
            r_waitCnt  <= '0;
            r_rspValid <= 1'b0;
            r_rspFault <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (w_accept) begin
                        r_waitCnt <= '0;
                        r_state   <= (WAIT_CYC == 0) ? c_stResp : c_stWait;
                    end
                end
                c_stWait: begin
                    if (w_enterResp) begin
                        r_state <= c_stResp;
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                c_stResp: begin
                    if (bus.rsp_ready) begin
                        r_state    <= c_stIdle;
                        r_rspValid <= 1'b0;
                        r_rspFault <= 1'b0;
                        r_rspRdata <= '0;
                    end
                end
                default: r_state <= c_stIdle;
            endcase

            if (w_enterResp) begin
                r_rspValid <= 1'b1;
                r_rspFault <= w_fault;
                r_rspRdata <= (w_fault || w_write) ? '0 : w_loadData;
            end
        end
    end

    assign bus.req_ready = w_inIdle;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_fault = r_rspFault;
    assign bus.rsp_rdata = r_rspRdata;
    assign busy          = ~w_inIdle;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_ctrl
// Brief  : Randomized bench for data_mem_ctrl against a byte-array memory model.
// Rev    : 1.0
// ============================================================================
module tb_data_mem_ctrl;
    import mips_mem_pkg::*;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 256;
    localparam int ADDR_W   = 32;
    localparam int WAIT_CYC = 2;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .CLK   (clk),
        .reset (resetN),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          accPos;
    } exp_t;

    int         tests  = 0;
    int         fails  = 0;
    int         posCnt = 0;
    exp_t       expQ[$];
    logic [7:0] mdl [0:DEPTH*4-1];
    logic       wasValid = 1'b0;

    always @(posedge clk) posCnt <= posCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Little-endian byte memory; misaligned addresses either fault or round down.
    function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] data, output logic flt);
        int          n;
        longint      a;
        logic [63:0] v;
        n    = 1 << sz;
        a    = longint'(addr);
        v    = '0;
        data = '0;
        flt  = (sz == 2'b11) || (a / 4 >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % n != 0) flt = 1'b1;
`else
        a = a - (a % n);
`endif
        if (!flt) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
                if (!uns && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
                data = v[31:0];
            end
        end
    endfunction

    // Compare process: every cycle a response is presented it must match the model.
    always @(negedge clk) begin
        if (resetN && bus.rsp_valid) begin
            if (expQ.size() == 0) begin
                check("unexpected response", 32'(bus.rsp_valid), 32'd0);
            end else begin
                if (!wasValid) check("rsp latency", 32'(posCnt - expQ[0].accPos), 32'(WAIT_CYC));
                check("rsp_rdata", bus.rsp_rdata, expQ[0].data);
                check("rsp_fault", 32'(bus.rsp_fault), 32'(expQ[0].fault));
                check("busy in resp", 32'(busy), 32'd1);
            end
        end else if (wasValid && expQ.size() != 0) begin
            expQ.pop_front();
        end
        wasValid <= bus.rsp_valid;
    end

    task automatic doReq(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] got, output logic gotFlt);
        exp_t e;
        int   guard;
        model(w, sz, uns, addr, wd, e.data, e.fault);
        @(negedge clk);
        check("req_ready idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        e.accPos = posCnt + 1;
        expQ.push_back(e);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom % 2);
        bus.req_size     = 2'($urandom % 4);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        check("busy after accept", 32'(busy), 32'd1);
        check("req_ready while busy", 32'(bus.req_ready), 32'd0);
        guard = 0;
        while (!bus.rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("rsp_valid within bound", 32'(bus.rsp_valid), 32'd1);
        got    = bus.rsp_rdata;
        gotFlt = bus.rsp_fault;
        for (int k = 0; k < hold; k++) begin
            bus.req_valid = 1'($urandom % 2);
            @(negedge clk);
        end
        // req_valid stays high across the handshake edge; it must not be accepted.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("busy after handshake", 32'(busy), 32'd0);
        check("rsp_valid after handshake", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic        gf;
        logic        w;
        logic        uns;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] oldWord;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);

        for (int i = 0; i < 16; i++) doReq(1'b1, c_sizeWord, 1'b0, 32'(i * 4), $urandom, 0, got, gf);

        doReq(1'b1, c_sizeWord, 1'b0, 32'h10, 32'hDEADBEEF, 0, got, gf);
        check("store word rdata", got, 32'd0);
        check("store word fault", 32'(gf), 32'd0);
        doReq(1'b0, c_sizeWord, 1'b0, 32'h10, 32'h0, 1, got, gf);
        check("load word 0x10", got, 32'hDEADBEEF);
        check("load word 0x10 fault", 32'(gf), 32'd0);

        doReq(1'b1, c_sizeByte, 1'b0, 32'h11, 32'h80, 0, got, gf);
        doReq(1'b0, c_sizeByte, 1'b0, 32'h11, 32'h0, 0, got, gf);
        check("load byte signed 0x11", got, 32'hFFFFFF80);
        doReq(1'b0, c_sizeByte, 1'b1, 32'h11, 32'h0, 0, got, gf);
        check("load byte unsigned 0x11", got, 32'h00000080);
        doReq(1'b0, c_sizeWord, 1'b0, 32'h10, 32'h0, 0, got, gf);
        check("load word after byte store", got, 32'hDEAD80EF);

        doReq(1'b0, c_sizeWord, 1'b0, 32'h400, 32'h0, 0, got, gf);
        check("out of range fault", 32'(gf), 32'd1);
        check("out of range rdata", got, 32'd0);
        doReq(1'b1, c_sizeWord, 1'b0, 32'h400, 32'h55555555, 0, got, gf);
        check("out of range store fault", 32'(gf), 32'd1);
        doReq(1'b0, c_sizeWord, 1'b0, 32'h10, 32'h0, 0, got, gf);
        check("memory unchanged after fault", got, 32'hDEAD80EF);

        doReq(1'b0, c_sizeHalf, 1'b1, 32'h13, 32'h0, 0, got, gf);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misaligned half fault", 32'(gf), 32'd1);
        check("misaligned half rdata", got, 32'd0);
`else
        check("misaligned half fault", 32'(gf), 32'd0);
        check("misaligned half rdata", got, 32'h0000DEAD);
`endif

        // Store aborted by reset while waiting must leave the old word in place.
        oldWord = {mdl[32'h23], mdl[32'h22], mdl[32'h21], mdl[32'h20]};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = c_sizeWord;
        bus.req_addr  = 32'h20;
        bus.req_wdata = ~oldWord;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("busy before abort", 32'(busy), 32'd1);
        resetN = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
        resetN = 1'b1;
        doReq(1'b0, c_sizeWord, 1'b0, 32'h20, 32'h0, 5, got, gf);
        check("aborted store not written", got, oldWord);
        doReq(1'b0, c_sizeWord, 1'b0, 32'h10, 32'h0, 5, got, gf);
        check("held response rdata", got, 32'hDEAD80EF);

        for (int t = 0; t < 150; t++) begin
            w    = 1'($urandom % 2);
            uns  = 1'($urandom % 2);
            sz   = 2'($urandom % 4);
            addr = ($urandom % 10 == 0) ? 32'h400 + 32'($urandom % 64) : 32'($urandom % 64);
            doReq(w, sz, uns, addr, $urandom, int'($urandom % 4), got, gf);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
